circuit_resp_misr: RTL and testbench
====================================

Name: circuit_resp_misr

Overview:
- Downstream response compactor for the 12-in/4-out ECO test circuit.
- Consumes one 4-bit output vector per accepted handshake, folds it into a multiple-input signature register (MISR), and counts vectors.
- After NUM_VEC vectors it compares the signature with an expected value and reports pass/fail.
- Sits between the circuit's output pins (via a capture register) and the test controller.

Parameters:
- OUT_W, 4: width of one circuit response vector; must be ≤ MISR_W.
- MISR_W, 16: signature width.
- POLY, 16'h1021: feedback polynomial, MISR_W bits, applied when the shifted-out MSB is 1.
- SEED, 16'h0000: signature value loaded on start.
- NUM_VEC, 256: vectors per run; must be ≥ 1.
- CNT_W, 9: vector counter width; must hold NUM_VEC.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run (honoured in IDLE and DONE only).
- exp_sig  in  MISR_W  expected signature, sampled on the accepted start cycle.
- in_valid  in  1  response vector valid.
- in_data  in  OUT_W  circuit response vector (bit i = output i, e.g. {n33,n18,n10,n6}).
- in_ready  out  1  block can accept a vector.
- sig  out  MISR_W  current signature register.
- vec_cnt  out  CNT_W  vectors accepted in the current run.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid while done=1; 1 when sig == latched exp_sig.

Behaviour:
- Reset (async assert, synchronous-safe deassert) forces:
  - state=IDLE, sig=SEED, vec_cnt=0, exp latch=0.
  - in_ready=0, busy=0, done=0, pass=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start → RUN; sig←SEED, vec_cnt←0, latch exp_sig.
  - RUN: in_ready=1 combinationally from state. Accept = in_valid & in_ready.
  - On accept:
    - sig ← ({sig[MISR_W-2:0],1'b0} ^ (sig[MISR_W-1] ? POLY : 0)) ^ zero-extended in_data.
    - vec_cnt ← vec_cnt+1.
  - Accept that brings vec_cnt to NUM_VEC → DONE next cycle. That final vector is included in sig.
  - DONE: done=1, in_ready=0, sig and vec_cnt hold.
    - pass registered on the DONE-entry edge as (next sig == exp latch). It holds until the next start.
  - DONE + start → RUN with the same reload as from IDLE; done and pass clear on that edge.
- start while in RUN is ignored: no reload, no restart.
- in_valid while not in RUN: no effect, no backpressure error, data dropped.
- in_data is ignored when in_valid=0. sig is unchanged on non-accept cycles.
- Latency: sig reflects an accepted vector one cycle after the accept edge. done rises one cycle after the last accept.
- vec_cnt never wraps within a run; it stops at NUM_VEC.
- Reset mid-run aborts immediately to IDLE with reset values; there is no partial-result retention.
- NUM_VEC=1: a single accept goes directly to DONE.

Optional Feature:
- Macro RESP_MISR_XMASK_EN.
- When defined:
  - Extra input port in_xmask (OUT_W bits).
  - Compacted data = in_data & ~in_xmask, so masked outputs (don't-care / X) do not perturb the signature.
  - Extra output xmask_seen (1 bit): cleared on start, set on any accept with in_xmask≠0, held through DONE.
- When undefined: neither port exists and in_data is compacted unmasked. Behaviour is otherwise identical.

Test Plan:
- Reset value check: assert rst_n=0 mid-RUN after 5 accepts → same cycle sig=0x0000, vec_cnt=0, busy=0, in_ready=0. After release, state stays IDLE.
- Basic fold, SEED=0, POLY=0x1021:
  - start, accept 4'hF → sig=0x000F.
  - accept 4'h0 → sig=0x001E.
  - accept 4'h1 → sig=0x003D.
- Feedback path, SEED=0x8000: start, accept 4'h0 → sig=0x1021. Then accept 4'h2 → sig=0x2040.
- Run completion, NUM_VEC=4, in_valid toggling 1,0,1,1,0,1 with data 1,x,2,3,x,4:
  - exactly 4 accepts.
  - done rises the cycle after the 4th.
  - with exp_sig = model value → pass=1; with exp_sig=model^1 → pass=0.
- Ignored events:
  - start pulsed during RUN → sig/vec_cnt unaffected.
  - in_valid=1 in IDLE and DONE → sig unchanged, in_ready=0.
  - start in DONE → sig=SEED, done=0 next cycle.
- XMASK build: in_data=4'hF, in_xmask=4'hC, SEED=0 → sig=0x0003, xmask_seen=1. Next start clears xmask_seen.

Source files
------------

// File: rtl/circuit_resp_misr.sv
// circuit_resp_misr: response compactor for the 12-in/4-out ECO test circuit.
// Each accepted response vector is folded into a multiple-input signature
// register. After NUM_VEC vectors the signature is compared against the
// expected value that was latched at start, and pass/fail is reported.
//
// Optional build macro RESP_MISR_XMASK_EN adds the in_xmask input and the
// xmask_seen output. Masked response bits are forced to zero before
// compaction, so don't-care outputs cannot disturb the signature.
module circuit_resp_misr #(
   parameter int                OUT_W   = 4,
   parameter int                MISR_W  = 16,
   parameter logic [MISR_W-1:0] POLY    = 16'h1021,
   parameter logic [MISR_W-1:0] SEED    = 16'h0000,
   parameter int                NUM_VEC = 256,
   parameter int                CNT_W   = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [MISR_W-1:0] exp_sig,
   input  logic              in_valid,
   input  logic [OUT_W-1:0]  in_data,
`ifdef RESP_MISR_XMASK_EN
   input  logic [OUT_W-1:0]  in_xmask,
   output logic              xmask_seen,
`endif
   output logic              in_ready,
   output logic [MISR_W-1:0] sig,
   output logic [CNT_W-1:0]  vec_cnt,
   output logic              busy,
   output logic              done,
   output logic              pass
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Count value held just before the final accept of a run.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VEC - 1);

   state_t            state_q;
   state_t            state_d;
   logic [MISR_W-1:0] exp_q;
   logic [MISR_W-1:0] sig_d;
   logic [MISR_W-1:0] comp_data;
   logic [CNT_W-1:0]  cnt_d;
   logic              pass_d;
   logic              load;
`ifdef RESP_MISR_XMASK_EN
   logic              xseen_d;
`endif

   // One MISR shift: shift left, apply the polynomial when the MSB falls
   // out, then fold in the (already zero-extended) response vector.
   function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] s,
                                                   input logic [MISR_W-1:0] d);
      logic [MISR_W-1:0] fb;
      fb = s[MISR_W-1] ? POLY : '0;
      return {s[MISR_W-2:0], 1'b0} ^ fb ^ d;
   endfunction

   // Response vector actually compacted, zero-extended to signature width.
   always_comb begin
`ifdef RESP_MISR_XMASK_EN
      comp_data = MISR_W'(in_data & ~in_xmask);
`else
      comp_data = MISR_W'(in_data);
`endif
   end

   // Next-state, datapath update and state-decoded outputs.
   always_comb begin
      state_d  = state_q;
      sig_d    = sig;
      cnt_d    = vec_cnt;
      pass_d   = pass;
      load     = 1'b0;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
`ifdef RESP_MISR_XMASK_EN
      xseen_d  = xmask_seen;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               load    = 1'b1;
               sig_d   = SEED;
               cnt_d   = '0;
               pass_d  = 1'b0;
`ifdef RESP_MISR_XMASK_EN
               xseen_d = 1'b0;
`endif
            end
         end
         RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            // start is deliberately not decoded here: a run cannot restart.
            if (in_valid) begin
               sig_d = misr_step(sig, comp_data);
               cnt_d = vec_cnt + CNT_W'(1);
`ifdef RESP_MISR_XMASK_EN
               if (in_xmask != '0) begin
                  xseen_d = 1'b1;
               end
`endif
               if (vec_cnt == LAST_CNT) begin
                  state_d = DONE;
                  // Verdict uses the signature that includes the final vector.
                  pass_d  = (sig_d == exp_q);
               end
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_d = RUN;
               load    = 1'b1;
               sig_d   = SEED;
               cnt_d   = '0;
               pass_d  = 1'b0;
`ifdef RESP_MISR_XMASK_EN
               xseen_d = 1'b0;
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, signature, counter, verdict and expected-value registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sig     <= SEED;
         vec_cnt <= '0;
         exp_q   <= '0;
         pass    <= 1'b0;
      end else begin
         state_q <= state_d;
         sig     <= sig_d;
         vec_cnt <= cnt_d;
         pass    <= pass_d;
         if (load) begin
            exp_q <= exp_sig;
         end
      end
   end

`ifdef RESP_MISR_XMASK_EN
   // Sticky flag: some response bit of this run was masked out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xmask_seen <= 1'b0;
      end else begin
         xmask_seen <= xseen_d;
      end
   end
`endif

endmodule

// File: tb/tb_circuit_resp_misr.sv
// Bench for circuit_resp_misr: two instances (SEED 0x0000 and SEED 0x8000,
// NUM_VEC=4) share all inputs; a behavioural model predicts both.
module tb_circuit_resp_misr;

   localparam int NV = 4;
   localparam int SEED_A = 'h0000;
   localparam int SEED_B = 'h8000;
`ifdef RESP_MISR_XMASK_EN
   localparam logic [3:0] XMK = 4'hF;
`else
   localparam logic [3:0] XMK = 4'h0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] exp_sig = '0;
   logic        in_valid = 1'b0;
   logic [3:0]  in_data = '0;
`ifdef RESP_MISR_XMASK_EN
   logic [3:0]  in_xmask = '0;
   logic        a_xseen, b_xseen;
`endif
   logic        a_rdy, b_rdy, a_busy, b_busy, a_done, b_done, a_pass, b_pass;
   logic [15:0] a_sig, b_sig;
   logic [2:0]  a_cnt, b_cnt;

   int n_chk = 0;
   int n_fail = 0;

   // model state: 0 idle, 1 run, 2 done
   int m_state, m_a, m_b, m_cnt, m_exp, m_pa, m_pb, m_xs;

   always #5 clk = ~clk;

   circuit_resp_misr #(.OUT_W(4), .MISR_W(16), .POLY(16'h1021), .SEED(16'h0000),
                       .NUM_VEC(NV), .CNT_W(3)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .exp_sig(exp_sig),
      .in_valid(in_valid), .in_data(in_data),
`ifdef RESP_MISR_XMASK_EN
      .in_xmask(in_xmask), .xmask_seen(a_xseen),
`endif
      .in_ready(a_rdy), .sig(a_sig), .vec_cnt(a_cnt), .busy(a_busy),
      .done(a_done), .pass(a_pass));

   circuit_resp_misr #(.OUT_W(4), .MISR_W(16), .POLY(16'h1021), .SEED(16'h8000),
                       .NUM_VEC(NV), .CNT_W(3)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .exp_sig(exp_sig),
      .in_valid(in_valid), .in_data(in_data),
`ifdef RESP_MISR_XMASK_EN
      .in_xmask(in_xmask), .xmask_seen(b_xseen),
`endif
      .in_ready(b_rdy), .sig(b_sig), .vec_cnt(b_cnt), .busy(b_busy),
      .done(b_done), .pass(b_pass));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Signature polynomial arithmetic: multiply by x modulo the 17-bit
   // polynomial x^16 + POLY, then add (xor) the response vector.
   function automatic int fold(input int s, input int d);
      int t;
      t = s * 2;
      if (t >= 65536) t = (t - 65536) ^ 'h1021;
      return t ^ d;
   endfunction

   task automatic model_reset();
      m_state = 0; m_a = SEED_A; m_b = SEED_B; m_cnt = 0;
      m_exp = 0; m_pa = 0; m_pb = 0; m_xs = 0;
   endtask

   task automatic model_edge(input logic v, input logic [3:0] d, input logic s,
                             input logic [15:0] e, input logic [3:0] xm);
      int dm;
      dm = int'(d & ~(xm & XMK));
      if (m_state != 1 && s) begin
         m_state = 1; m_a = SEED_A; m_b = SEED_B; m_cnt = 0;
         m_exp = int'(e); m_pa = 0; m_pb = 0; m_xs = 0;
      end else if (m_state == 1 && v) begin
         m_a = fold(m_a, dm);
         m_b = fold(m_b, dm);
         m_cnt++;
         if ((xm & XMK) != 4'h0) m_xs = 1;
         if (m_cnt == NV) begin
            m_state = 2;
            m_pa = (m_a == m_exp) ? 1 : 0;
            m_pb = (m_b == m_exp) ? 1 : 0;
         end
      end
   endtask

   task automatic check_all();
      chk("sig_a", 32'(a_sig), m_a);
      chk("sig_b", 32'(b_sig), m_b);
      chk("vec_cnt", 32'(a_cnt), m_cnt);
      chk("vec_cnt_b", 32'(b_cnt), m_cnt);
      chk("busy", 32'(a_busy), (m_state == 1) ? 1 : 0);
      chk("in_ready", 32'(a_rdy), (m_state == 1) ? 1 : 0);
      chk("done", 32'(a_done), (m_state == 2) ? 1 : 0);
      chk("done_b", 32'(b_done), (m_state == 2) ? 1 : 0);
      if (m_state == 2) begin
         chk("pass_a", 32'(a_pass), m_pa);
         chk("pass_b", 32'(b_pass), m_pb);
      end
`ifdef RESP_MISR_XMASK_EN
      chk("xmask_seen", 32'(a_xseen), m_xs);
`endif
   endtask

   task automatic cyc(input logic v, input logic [3:0] d, input logic s,
                      input logic [15:0] e, input logic [3:0] xm);
      in_valid = v; in_data = d; start = s; exp_sig = e;
`ifdef RESP_MISR_XMASK_EN
      in_xmask = xm;
`endif
      @(posedge clk);
      model_edge(v, d, s, e, xm);
      #1;
      check_all();
      in_valid = 1'b0; start = 1'b0;
   endtask

   task automatic run_pattern(input logic [15:0] e);
      cyc(1'b0, 4'h0, 1'b1, e, 4'h0);
      cyc(1'b1, 4'h1, 1'b0, 16'h0, 4'h0);
      cyc(1'b0, 4'h9, 1'b0, 16'h0, 4'h0);
      cyc(1'b1, 4'h2, 1'b0, 16'h0, 4'h0);
      cyc(1'b1, 4'h3, 1'b0, 16'h0, 4'h0);
      chk("pat_done_early", 32'(a_done), 0);
      cyc(1'b0, 4'hA, 1'b0, 16'h0, 4'h0);
      cyc(1'b1, 4'h4, 1'b0, 16'h0, 4'h0);
      chk("pat_done", 32'(a_done), 1);
      chk("pat_cnt", 32'(a_cnt), 4);
      chk("pat_sig_a", 32'(a_sig), 32'h0002);
      chk("pat_sig_b", 32'(b_sig), 32'h810A);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("rst_sig", 32'(a_sig), 32'h0000);
      chk("rst_pass", 32'(a_pass), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // idle, in_valid ignored
      cyc(1'b0, 4'h0, 1'b0, 16'h0, 4'h0);
      cyc(1'b1, 4'h5, 1'b0, 16'h0, 4'h0);
      chk("idle_sig", 32'(a_sig), 32'h0000);
      chk("idle_rdy", 32'(a_rdy), 0);

      // basic fold
      cyc(1'b0, 4'h0, 1'b1, 16'h0, 4'h0);
      cyc(1'b1, 4'hF, 1'b0, 16'h0, 4'h0);
      chk("fold_F", 32'(a_sig), 32'h000F);
      cyc(1'b1, 4'h0, 1'b0, 16'h0, 4'h0);
      chk("fold_0", 32'(a_sig), 32'h001E);
      cyc(1'b1, 4'h1, 1'b0, 16'h0, 4'h0);
      chk("fold_1", 32'(a_sig), 32'h003D);

      // start during RUN ignored
      cyc(1'b0, 4'h0, 1'b1, 16'hFFFF, 4'h0);
      chk("run_start_sig", 32'(a_sig), 32'h003D);
      chk("run_start_cnt", 32'(a_cnt), 3);
      cyc(1'b1, 4'h2, 1'b0, 16'h0, 4'h0);
      chk("fin_done", 32'(a_done), 1);
      chk("fin_sig", 32'(a_sig), 32'h0078);

      // DONE ignores in_valid, start reloads
      cyc(1'b1, 4'h7, 1'b0, 16'h0, 4'h0);
      chk("done_hold_sig", 32'(a_sig), 32'h0078);
      chk("done_rdy", 32'(a_rdy), 0);
      cyc(1'b0, 4'h0, 1'b1, 16'h0, 4'h0);
      chk("restart_sig", 32'(a_sig), 32'h0000);
      chk("restart_done", 32'(a_done), 0);

      // feedback path on the SEED=0x8000 instance
      cyc(1'b1, 4'h0, 1'b0, 16'h0, 4'h0);
      chk("fb_1021", 32'(b_sig), 32'h1021);
      cyc(1'b1, 4'h2, 1'b0, 16'h0, 4'h0);
      chk("fb_2040", 32'(b_sig), 32'h2040);

      // reset mid-run takes effect without a clock edge
      cyc(1'b1, 4'h3, 1'b0, 16'h0, 4'h0);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_sig", 32'(a_sig), 32'h0000);
      chk("arst_sig_b", 32'(b_sig), 32'h8000);
      chk("arst_cnt", 32'(a_cnt), 0);
      chk("arst_busy", 32'(a_busy), 0);
      chk("arst_rdy", 32'(a_rdy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b1, 4'h6, 1'b0, 16'h0, 4'h0);
      chk("post_rst_busy", 32'(a_busy), 0);

      // run completion, matching and mismatching expected signature
      run_pattern(16'h0002);
      chk("pat_pass_a", 32'(a_pass), 1);
      chk("pat_pass_b", 32'(b_pass), 0);
      run_pattern(16'h0003);
      chk("pat_fail_a", 32'(a_pass), 0);

`ifdef RESP_MISR_XMASK_EN
      cyc(1'b0, 4'h0, 1'b1, 16'h0, 4'h0);
      cyc(1'b1, 4'hF, 1'b0, 16'h0, 4'hC);
      chk("xm_sig", 32'(a_sig), 32'h0003);
      chk("xm_seen", 32'(a_xseen), 1);
      repeat (3) cyc(1'b1, 4'h1, 1'b0, 16'h0, 4'h0);
      chk("xm_seen_done", 32'(a_xseen), 1);
      cyc(1'b0, 4'h0, 1'b1, 16'h0, 4'h0);
      chk("xm_seen_clr", 32'(a_xseen), 0);
`endif

      // randomized traffic with stray start pulses
      for (int r = 0; r < 10; r++) begin
         cyc(1'b0, 4'h0, 1'b1, 16'($urandom), 4'h0);
         for (int k = 0; k < 14; k++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 9) == 0),
                16'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
